// File: rtl/ma_lsu_stage.sv
// rtl/ma_lsu_stage.sv - MA-stage load/store unit with a request/acknowledge data-memory port
// The LSU_TIMEOUT_EN macro enables the REQ watchdog, which aborts with bus_err after TIMEOUT_CYCLES.
module ma_lsu_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        M_mem_rd,
    input  logic        M_mem_wr,
    input  logic [2:0]  M_funct3,
    input  logic [31:0] M_alu_o,
    input  logic [31:0] M_wd,
    output logic [31:0] M_dm_rd,
    output logic        stall_M,
    output logic        misalign,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t      state;
    logic        op;
    logic        mis;
    logic [1:0]  sz;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    logic [1:0]  lat_off;
    logic [2:0]  lat_f3;
    logic        lat_ld;

    assign op = M_mem_rd | M_mem_wr;

    // Size class: 0 byte, 1 half, 2 word; reserved encodings fall through to word.
    always_comb begin
        sz = 2'd2;
        case (M_funct3)
            3'b000, 3'b100: sz = 2'd0;
            3'b001, 3'b101: sz = 2'd1;
            default:        sz = 2'd2;
        endcase
    end

    assign mis = ((sz == 2'd2) && (M_alu_o[1:0] != 2'b00)) ||
                 ((sz == 2'd1) && M_alu_o[0]);

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = M_wd;
        case (sz)
            2'd0: begin
                be_c    = 4'b0001 << M_alu_o[1:0];
                wdata_c = {4{M_wd[7:0]}};
            end
            2'd1: begin
                be_c    = M_alu_o[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{M_wd[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = M_wd;
            end
        endcase
    end

    assign misalign = op & mis;
    assign stall_M  = (state == S_REQ) || ((state == S_IDLE) && op && !mis);

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'd0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
`else
    logic unused_cfg;
    assign unused_cfg = (^ERR_DATA) ^ (TIMEOUT_CYCLES == 0);
    assign bus_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            M_dm_rd    <= 32'd0;
            lat_off    <= 2'd0;
            lat_f3     <= 3'd0;
            lat_ld     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_err    <= 1'b0;
            cnt        <= '0;
`endif
        end else begin
`ifdef LSU_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (op && !mis) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= M_mem_wr;
                        dmem_addr  <= {M_alu_o[31:2], 2'b00};
                        dmem_be    <= be_c;
                        dmem_wdata <= wdata_c;
                        lat_off    <= M_alu_o[1:0];
                        lat_f3     <= M_funct3;
                        lat_ld     <= M_mem_rd & ~M_mem_wr;
`ifdef LSU_TIMEOUT_EN
                        cnt        <= '0;
`endif
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (lat_ld)
                            M_dm_rd <= load_ext(dmem_rdata, lat_off, lat_f3);
                        state <= S_DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    // Ack on the limit cycle takes the branch above, so it wins.
                    else if (cnt == LIMIT) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        if (lat_ld)
                            M_dm_rd <= ERR_DATA;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ma_lsu_stage.sv
// tb/tb_ma_lsu_stage.sv - directed self-checking bench for ma_lsu_stage
module tb_ma_lsu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        M_mem_rd, M_mem_wr;
    logic [2:0]  M_funct3;
    logic [31:0] M_alu_o, M_wd;
    logic [31:0] M_dm_rd;
    logic        stall_M, misalign, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int errors = 0;
    int hi;

    ma_lsu_stage #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .M_mem_rd(M_mem_rd), .M_mem_wr(M_mem_wr), .M_funct3(M_funct3),
        .M_alu_o(M_alu_o), .M_wd(M_wd), .M_dm_rd(M_dm_rd),
        .stall_M(stall_M), .misalign(misalign), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        M_mem_rd = rd;
        M_mem_wr = wr;
        M_funct3 = f3;
        M_alu_o  = addr;
        M_wd     = wd;
    endtask

    // Memory model: acks after `waits` REQ cycles; returns count of stalled cycles seen.
    task automatic run(input int waits, input logic [31:0] rdata, output int n_hi);
        int reqc;
        n_hi = 0;
        reqc = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (!stall_M) break;
            n_hi++;
            if (dmem_req) begin
                if (reqc == waits) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                reqc++;
            end
            @(posedge clk);
            #2;
            dmem_ack = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        tick; tick;
        #1;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_rd", M_dm_rd, 32'd0);
        chk("rst_stall", {31'd0, stall_M}, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_buserr", {31'd0, bus_err}, 32'd0);
        rst_n = 1'b1;
        tick;

        // lb at 0x1003, ack in first REQ cycle
        set_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0);
        #1 chk("lb_stall0", {31'd0, stall_M}, 32'd1);
        tick;
        #1;
        chk("lb_req", {31'd0, dmem_req}, 32'd1);
        chk("lb_addr", dmem_addr, 32'h0000_1000);
        chk("lb_be", {28'd0, dmem_be}, 32'h8);
        chk("lb_we", {31'd0, dmem_we}, 32'd0);
        chk("lb_stall1", {31'd0, stall_M}, 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80AA_55CC;
        tick;
        dmem_ack = 1'b0;
        #1;
        chk("lb_stall2", {31'd0, stall_M}, 32'd0);
        chk("lb_data", M_dm_rd, 32'hFFFF_FF80);
        chk("lb_req_drop", {31'd0, dmem_req}, 32'd0);
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick;

        // lhu at 0x2002, ack after 4 wait cycles
        set_op(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0);
        run(4, 32'hBEEF_1234, hi);
        chk("lhu_stall_cycles", hi, 32'd6);
        chk("lhu_data", M_dm_rd, 32'h0000_BEEF);
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick;

        // sb at 0x3001
        set_op(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h1234_5678);
        tick;
        #1;
        chk("sb_we", {31'd0, dmem_we}, 32'd1);
        chk("sb_be", {28'd0, dmem_be}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h7878_7878);
        chk("sb_addr", dmem_addr, 32'h0000_3000);
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        #1;
        chk("sb_stall_done", {31'd0, stall_M}, 32'd0);
        chk("sb_rd_held", M_dm_rd, 32'h0000_BEEF);
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick;

        // sh at 0x7002
        set_op(1'b0, 1'b1, 3'b001, 32'h0000_7002, 32'h1234_BEEF);
        tick;
        #1;
        chk("sh_be", {28'd0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        run(1, 32'd0, hi);
        chk("sh_stall_cycles", hi, 32'd2);
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick;

        // rd and wr together with funct3=011: a word store
        set_op(1'b1, 1'b1, 3'b011, 32'h0000_6000, 32'hAABB_CCDD);
        tick;
        #1;
        chk("both_we", {31'd0, dmem_we}, 32'd1);
        chk("both_be", {28'd0, dmem_be}, 32'hF);
        chk("both_wdata", dmem_wdata, 32'hAABB_CCDD);
        run(0, 32'h1111_1111, hi);
        chk("both_rd_held", M_dm_rd, 32'h0000_BEEF);
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick;

        // lh at 0x8000 (sign), lbu at 0x9002 (zero)
        set_op(1'b1, 1'b0, 3'b001, 32'h0000_8000, 32'd0);
        run(2, 32'h1234_F00D, hi);
        chk("lh_stall_cycles", hi, 32'd4);
        chk("lh_data", M_dm_rd, 32'hFFFF_F00D);
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick;
        set_op(1'b1, 1'b0, 3'b100, 32'h0000_9002, 32'd0);
        run(0, 32'h00C3_0000, hi);
        chk("lbu_data", M_dm_rd, 32'h0000_00C3);
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick;

        // Misaligned lw and sh: no request, no stall
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'd0);
        #1;
        chk("mis_lw_flag", {31'd0, misalign}, 32'd1);
        chk("mis_lw_stall", {31'd0, stall_M}, 32'd0);
        tick;
        #1 chk("mis_lw_req", {31'd0, dmem_req}, 32'd0);
        tick;
        #1 chk("mis_lw_rd_held", M_dm_rd, 32'h0000_00C3);
        set_op(1'b0, 1'b1, 3'b001, 32'h0000_5001, 32'hFFFF_FFFF);
        #1 chk("mis_sh_flag", {31'd0, misalign}, 32'd1);
        tick;
        #1 chk("mis_sh_req", {31'd0, dmem_req}, 32'd0);
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        #1 chk("aligned_noflag", {31'd0, misalign}, 32'd0);

        // Stray ack in IDLE is ignored
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5555_5555;
        tick;
        dmem_ack = 1'b0;
        #1;
        chk("idle_ack_rd", M_dm_rd, 32'h0000_00C3);
        chk("idle_ack_stall", {31'd0, stall_M}, 32'd0);

        // Async reset mid-REQ
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_A000, 32'd0);
        tick;
        #1 chk("mid_req", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        #1;
        chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("mid_rst_rd", M_dm_rd, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_M}, 32'd0);
        tick;
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h7777_7777;
        tick;
        dmem_ack = 1'b0;
        #1;
        chk("post_rst_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("post_rst_ack_rd", M_dm_rd, 32'd0);
        chk("post_rst_ack_stall", {31'd0, stall_M}, 32'd0);

        // lw with no ack
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_B000, 32'd0);
        run(1000, 32'd0, hi);
`ifdef LSU_TIMEOUT_EN
        chk("to_stall_cycles", hi, 32'd5);
        chk("to_buserr", {31'd0, bus_err}, 32'd1);
        chk("to_data", M_dm_rd, 32'hDEAD_BEEF);
        chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick;
        #1;
        chk("to_buserr_clear", {31'd0, bus_err}, 32'd0);
        chk("to_idle_stall", {31'd0, stall_M}, 32'd0);
`else
        chk("noto_stall_held", hi, 32'd40);
        chk("noto_req_held", {31'd0, dmem_req}, 32'd1);
        chk("noto_buserr", {31'd0, bus_err}, 32'd0);
        set_op(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ma_lsu_stage.md
Name: ma_lsu_stage

Overview:
- Memory-access-stage load/store unit between the EX/MA register and the MA/WB register.
- Turns the MA-stage ALU address, store data and funct3 into a request/acknowledge transaction on a variable-latency data-memory port.
- Aligns and sign/zero-extends load data and presents it as M_dm_rd to the MA/WB register.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in REQ without dmem_ack before abort (only with LSU_TIMEOUT_EN).
- ERR_DATA, 32'hDEADBEEF: load result returned on timeout abort.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- M_mem_rd  in  1  MA-stage instruction is a load.
- M_mem_wr  in  1  MA-stage instruction is a store.
- M_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- M_alu_o  in  32  effective byte address.
- M_wd  in  32  store data (rs2, unshifted).
- M_dm_rd  out  32  aligned/extended load result to MA/WB register.
- stall_M  out  1  holds PC, IF/ID, ID/EX, EX/MA; MA/WB captures only when low.
- misalign  out  1  combinational: current access misaligned, suppressed.
- bus_err  out  1  one-cycle pulse on timeout abort.
- dmem_req  out  1  request valid; registered.
- dmem_we  out  1  write enable; registered.
- dmem_addr  out  32  word address {addr[31:2],2'b00}; registered.
- dmem_be  out  4  byte enables; registered.
- dmem_wdata  out  32  lane-replicated store data; registered.
- dmem_ack  in  1  one-cycle completion strobe.
- dmem_rdata  in  32  read word, valid with dmem_ack.

Behaviour:
- Reset (async, rst_n=0): state IDLE; dmem_req, dmem_we, bus_err = 0; dmem_addr, dmem_be, dmem_wdata = 0; M_dm_rd = 0; timeout counter 0.
- Reset mid-transaction: dmem_req drops immediately and the transaction is abandoned. An ack arriving after reset release while in IDLE is ignored.
- op = M_mem_rd | M_mem_wr. Both high at once: treated as a store only.
- Misaligned: w with addr[1:0]≠0, or h/hu with addr[0]=1.
  - misalign=1, no request, stall_M=0.
  - M_dm_rd is held at its previous value; a misaligned store writes nothing.
- funct3 values 011, 110, 111 are treated as w.
- Store lanes:
  - sb: be = 4'b0001 << addr[1:0]; wdata = {4{wd[7:0]}}.
  - sh: be = addr[1] ? 1100 : 0011; wdata = {2{wd[15:0]}}.
  - sw: be = 1111; wdata = wd.
- Loads: be is computed the same way as for stores and is informational only.
- FSM states:
  - IDLE: op and aligned → latch we/addr/be/wdata into the output registers, go to REQ. stall_M=1 combinationally in this cycle. No op → stall_M=0.
  - REQ: dmem_req=1, outputs held stable; stall_M=1.
    - dmem_ack=1, load → extract byte/half at addr[1:0], sign/zero-extend per funct3, register into M_dm_rd; go to DONE.
    - dmem_ack=1, store → M_dm_rd unchanged; go to DONE.
    - dmem_req deasserts on the clock edge that leaves REQ.
  - DONE: stall_M=0 for exactly one cycle; MA/WB captures. Next state is IDLE unconditionally, so a new instruction is never re-issued in DONE.
- Latency: ack in the first REQ cycle gives 3 cycles from op detection to MA/WB capture; each extra wait cycle adds 1.
- Back-to-back memory ops: one per 3 cycles minimum, no bubble merging.
- dmem_ack outside REQ: ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - On reaching TIMEOUT_CYCLES-1 without ack: dmem_req drops and bus_err pulses for 1 cycle; go to DONE.
  - A load returns M_dm_rd=ERR_DATA; a store is dropped.
  - Ack arriving in the same cycle as the limit: ack wins, no bus_err.
- Undefined: no counter, REQ waits indefinitely, and bus_err is tied 0.

Test Plan:
- Reset with dmem_req asserted mid-REQ → dmem_req=0 and M_dm_rd=0 asynchronously; a later ack is ignored; state is IDLE.
- lb at 0x1003, dmem_rdata=0x80AA55CC, ack on the first REQ cycle → dmem_addr=0x1000, M_dm_rd=0xFFFFFF80. stall_M pattern is 1,1,0.
- lhu at 0x2002, rdata=0xBEEF1234, ack after 4 wait cycles → M_dm_rd=0x0000BEEF. stall_M high for 6 cycles, then low 1.
- sb at 0x3001, wd=0x12345678 → dmem_we=1, be=0010, wdata=0x78787878; M_dm_rd unchanged.
- lw at 0x4002 → misalign=1, stall_M=0, dmem_req never asserts.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, lw with no ack → bus_err pulses once, M_dm_rd=0xDEADBEEF, DONE then IDLE. Without the macro → stall_M stays high.
